// File: rtl/psg_bus_pkg.sv
// rtl/psg_bus_pkg.sv - shared phase encoding and bus codes for the PSG bus master
package psg_bus_pkg;

  typedef enum logic [2:0] {IDLE, LATCH, GAP1, ACCESS, GAP2} psg_phase_t;

  // Bus codes are {BDIR, BC}
  localparam logic [1:0] BUS_INACTIVE = 2'b00;
  localparam logic [1:0] BUS_READ     = 2'b01;
  localparam logic [1:0] BUS_WRITE    = 2'b10;
  localparam logic [1:0] BUS_ADDR     = 2'b11;

endpackage

// File: rtl/psg_phase_timer.sv
// rtl/psg_phase_timer.sv - CE-gated down-counter pacing one bus phase
module psg_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         ce,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (ce && count != '0) begin
      count <= count - 1'b1;
    end
  end

  // Phase ends on the CE that would take the count from 1 to 0
  assign done = ce && (count == W'(1));

endmodule

// File: rtl/psg_bus_master.sv
// rtl/psg_bus_master.sv - turns single register requests into BDIR/BC sequences
// for up to four AY-3-8910/YM2149 chips sharing one data-out bus.
module psg_bus_master
  import psg_bus_pkg::*;
#(
  parameter int N_PSG      = 2,
  parameter int HOLD_CE    = 2,
  parameter int ADDR_CACHE = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               CE,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [1:0]         req_chip,
  input  logic [3:0]         req_addr,
  input  logic [7:0]         req_wdata,
  output logic               rsp_valid,
  output logic [7:0]         rsp_rdata,
  output logic [N_PSG-1:0]   PSG_BDIR,
  output logic [N_PSG-1:0]   PSG_BC,
  output logic [7:0]         PSG_DO,
  input  logic [8*N_PSG-1:0] PSG_DI
);

  psg_phase_t state;
  logic       cur_write;
  logic [1:0] cur_chip;
  logic [3:0] cur_addr;
  logic [7:0] cur_wdata;

  logic [N_PSG-1:0] cache_valid;
  logic [3:0]       cache_addr [N_PSG];

  logic       accept;
  logic       chip_ok;
  logic       hit;
  logic [7:0] di_sel;
  logic [1:0] code;
  logic       tmr_load;
  logic       tmr_done;

  assign req_ready = (state == IDLE) && !rsp_valid && !RESET;
  assign accept    = req_valid && req_ready;
  assign chip_ok   = 3'(req_chip) < 3'(N_PSG);
  assign tmr_load  = (state == IDLE && accept && chip_ok) ||
                     (tmr_done && (state == LATCH || state == GAP1 || state == ACCESS));

  psg_phase_timer #(.W(4)) u_timer (
    .clk      (CLK),
    .reset    (RESET),
    .load     (tmr_load),
    .load_val (4'(HOLD_CE)),
    .ce       (CE),
    .done     (tmr_done)
  );

  always_comb begin
    hit    = 1'b0;
    di_sel = 8'h00;
    for (int i = 0; i < N_PSG; i++) begin
      if (req_chip == 2'(i) && cache_valid[i] && cache_addr[i] == req_addr)
        hit = (ADDR_CACHE != 0);
      if (cur_chip == 2'(i))
        di_sel = PSG_DI[8*i +: 8];
    end
  end

  // Only the chip being served ever sees a non-inactive code
  always_comb begin
    case (state)
      LATCH:   code = BUS_ADDR;
      ACCESS:  code = cur_write ? BUS_WRITE : BUS_READ;
      default: code = BUS_INACTIVE;
    endcase
    PSG_BDIR = '0;
    PSG_BC   = '0;
    for (int i = 0; i < N_PSG; i++) begin
      PSG_BDIR[i] = (cur_chip == 2'(i)) && code[1];
      PSG_BC[i]   = (cur_chip == 2'(i)) && code[0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      cur_write   <= 1'b0;
      cur_chip    <= 2'd0;
      cur_addr    <= 4'd0;
      cur_wdata   <= 8'd0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 8'hFF;
      PSG_DO      <= 8'h00;
      cache_valid <= '0;
      for (int i = 0; i < N_PSG; i++) cache_addr[i] <= 4'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cur_write <= req_write;
            cur_chip  <= req_chip;
            cur_addr  <= req_addr;
            cur_wdata <= req_wdata;
            if (!chip_ok) begin
              rsp_valid <= 1'b1;
            end else if (hit) begin
              state <= ACCESS;
              if (req_write) PSG_DO <= req_wdata;
            end else begin
              state  <= LATCH;
              PSG_DO <= {4'h0, req_addr};
            end
          end
        end
        LATCH: begin
          if (tmr_done) begin
            state <= GAP1;
            for (int i = 0; i < N_PSG; i++) begin
              if (cur_chip == 2'(i)) begin
                cache_valid[i] <= 1'b1;
                cache_addr[i]  <= cur_addr;
              end
            end
          end
        end
        GAP1: begin
          if (tmr_done) begin
            state <= ACCESS;
            if (cur_write) PSG_DO <= cur_wdata;
          end
        end
        ACCESS: begin
          if (tmr_done) begin
            state <= GAP2;
            if (!cur_write) rsp_rdata <= di_sel;
          end
        end
        GAP2: begin
          if (tmr_done) begin
            state     <= IDLE;
            rsp_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
